pc_sequencer: RTL and testbench

- Control FSM that drives the 12-bit program counter's load, enable and load-value inputs.
- Runs the fetch/execute cycle: advance PC after each fetch; on execute, apply jump, call or return targets.
- Holds a small return-address stack for call/return.
- Sits between the instruction decoder and the program counter in the processor top level.

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/execute control FSM sitting between the instruction decoder and the
//   program counter. It drives the counter's load, enable and load value, and
//   keeps a small return-address stack for call/return.
//
//   Optional feature macro: SKIP_SEQ_EN
//     defined   -> skip_req is honoured in EXEC (lowest priority) and the SKIP
//                  state adds one extra counter increment.
//     undefined -> no SKIP state; skip_req is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   start      in   leave IDLE or HALT and begin fetching
//   pc_in      in   current counter value (return address source)
//   jump_req   in   EXEC request: load jump_addr
//   call_req   in   EXEC request: push pc_in, load jump_addr
//   ret_req    in   EXEC request: pop stack into the counter
//   halt_req   in   EXEC request: stop sequencing
//   skip_req   in   EXEC request: skip next instruction (SKIP_SEQ_EN only)
//   jump_addr  in   jump/call target
//   pc_load    out  counter load, one-cycle pulse in LOAD
//   pc_enable  out  counter increment enable (FETCH and SKIP)
//   pc_value   out  counter load value, valid while pc_load=1
//   fetch      out  high in FETCH
//   exec       out  high in EXEC; decoder requests are sampled this cycle
//   halted     out  high in HALT
//   stack_err  out  sticky overflow/underflow flag
//   sp         out  stack occupancy 0..DEPTH
//   dbg_state  out  current FSM state code, for debug and checkers
//
// Handshake: requests are level signals sampled only on the clock edge that
// closes EXEC; they are ignored in every other state. start is sampled only in
// IDLE and HALT.

module pc_sequencer #(
   parameter int AW    = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [AW-1:0]            pc_in,
   input  logic                     jump_req,
   input  logic                     call_req,
   input  logic                     ret_req,
   input  logic                     halt_req,
   input  logic                     skip_req,
   input  logic [AW-1:0]            jump_addr,
   output logic                     pc_load,
   output logic                     pc_enable,
   output logic [AW-1:0]            pc_value,
   output logic                     fetch,
   output logic                     exec,
   output logic                     halted,
   output logic                     stack_err,
   output logic [$clog2(DEPTH):0]   sp,
   output logic [2:0]               dbg_state
);

   localparam int IW  = $clog2(DEPTH);
   localparam int SPW = IW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_LOAD  = 3'd3;
`ifdef SKIP_SEQ_EN
   localparam logic [2:0] S_SKIP  = 3'd4;
`endif
   localparam logic [2:0] S_HALT  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   logic [2:0]     r_state;
   logic [SPW-1:0] r_sp;
   logic [AW-1:0]  r_stack [DEPTH];

   logic [2:0]     w_next;
   logic           w_push;
   logic           w_pop;
   logic           w_take_jaddr;
   logic           w_err;
   logic           w_en_next;
   logic [IW-1:0]  w_top_idx;

   assign w_top_idx = r_sp[IW-1:0] - IW'(1);

   always_comb begin
      w_next       = r_state;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_take_jaddr = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_FETCH;
         S_FETCH: w_next = S_EXEC;
         S_EXEC: begin
            // Priority: halt > ret > call > jump > skip; the rest are dropped.
            if (halt_req) begin
               w_next = S_HALT;
            end else if (ret_req) begin
               if (r_sp == '0) begin
                  w_err  = 1'b1;
                  w_next = S_ERR;
               end else begin
                  w_pop  = 1'b1;
                  w_next = S_LOAD;
               end
            end else if (call_req) begin
               if (r_sp == SPW'(DEPTH)) begin
                  w_err  = 1'b1;
                  w_next = S_ERR;
               end else begin
                  w_push       = 1'b1;
                  w_take_jaddr = 1'b1;
                  w_next       = S_LOAD;
               end
            end else if (jump_req) begin
               w_take_jaddr = 1'b1;
               w_next       = S_LOAD;
`ifdef SKIP_SEQ_EN
            end else if (skip_req) begin
               w_next = S_SKIP;
`endif
            end else begin
               w_next = S_FETCH;
            end
         end
         S_LOAD:  w_next = S_FETCH;
`ifdef SKIP_SEQ_EN
         S_SKIP:  w_next = S_FETCH;
`endif
         S_HALT:  if (start) w_next = S_FETCH;
         S_ERR:   w_next = S_ERR;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef SKIP_SEQ_EN
   assign w_en_next = (w_next == S_FETCH) || (w_next == S_SKIP);
`else
   assign w_en_next = (w_next == S_FETCH);
   logic w_unused_skip;
   assign w_unused_skip = skip_req;
`endif

   // Strobes are registered from the next-state value so every output comes
   // straight from a flop and lines up with the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sp      <= '0;
         pc_load   <= 1'b0;
         pc_enable <= 1'b0;
         pc_value  <= '0;
         fetch     <= 1'b0;
         exec      <= 1'b0;
         halted    <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         r_state   <= w_next;
         pc_load   <= (w_next == S_LOAD);
         pc_enable <= w_en_next;
         fetch     <= (w_next == S_FETCH);
         exec      <= (w_next == S_EXEC);
         halted    <= (w_next == S_HALT);
         if (w_err) stack_err <= 1'b1;
         if (w_push)
            r_sp <= r_sp + SPW'(1);
         else if (w_pop)
            r_sp <= r_sp - SPW'(1);
         if (w_pop)
            pc_value <= r_stack[w_top_idx];
         else if (w_take_jaddr)
            pc_value <= jump_addr;
      end
   end

   // Stack contents need no reset: sp alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[r_sp[IW-1:0]] <= pc_in;
   end

   assign sp        = r_sp;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. A small program-counter model sits
//   around the DUT (it loads on pc_load, increments on pc_enable, and feeds
//   pc_in), so fetch addresses can be compared with the expected program flow.
//   Directed scenarios are followed by a randomized run checked against an
//   instruction-level model (expected fetch address plus a return-address
//   queue). Build with +define+SKIP_SEQ_EN to cover the skip feature.

module tb_pc_sequencer;
   localparam int AW    = 12;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] pc_in;
   logic          jump_req, call_req, ret_req, halt_req, skip_req;
   logic [AW-1:0] jump_addr;
   logic          pc_load, pc_enable, fetch, exec, halted, stack_err;
   logic [AW-1:0] pc_value;
   logic [2:0]    sp;
   logic [2:0]    dbg_state;

   int total;
   int bad;

   // Strobe patterns {fetch, exec, pc_load, pc_enable, halted}
   localparam logic [4:0] ST_IDLE  = 5'b00000;
   localparam logic [4:0] ST_FETCH = 5'b10010;
   localparam logic [4:0] ST_EXEC  = 5'b01000;
   localparam logic [4:0] ST_LOAD  = 5'b00100;
   localparam logic [4:0] ST_SKIP  = 5'b00010;
   localparam logic [4:0] ST_HALT  = 5'b00001;

   pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pc_in     (pc_in),
      .jump_req  (jump_req),
      .call_req  (call_req),
      .ret_req   (ret_req),
      .halt_req  (halt_req),
      .skip_req  (skip_req),
      .jump_addr (jump_addr),
      .pc_load   (pc_load),
      .pc_enable (pc_enable),
      .pc_value  (pc_value),
      .fetch     (fetch),
      .exec      (exec),
      .halted    (halted),
      .stack_err (stack_err),
      .sp        (sp),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / environment ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] ctr;
   always @(posedge clk or posedge reset) begin
      if (reset)          ctr <= '0;
      else if (pc_load)   ctr <= pc_value;
      else if (pc_enable) ctr <= ctr + AW'(1);
   end
   assign pc_in = ctr;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1);
   end

   function automatic logic [4:0] obs();
      return {fetch, exec, pc_load, pc_enable, halted};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_reqs();
      jump_req  = 1'b0;
      call_req  = 1'b0;
      ret_req   = 1'b0;
      halt_req  = 1'b0;
      skip_req  = 1'b0;
      jump_addr = '0;
   endtask

   // Ends at a falling edge with the DUT in IDLE.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      clear_reqs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // From IDLE: ends at the falling edge of the first FETCH.
   task automatic begin_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      total++;
      if (obs() !== ST_IDLE || pc_value !== '0 || stack_err !== 1'b0 || sp !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got strobes=%b val=%h err=%b sp=%0d want 00000/000/0/0",
                  obs(), pc_value, stack_err, sp);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (obs() !== ST_IDLE) begin
            bad++;
            $display("FAIL idle_no_start: got %b want %b", obs(), ST_IDLE);
         end
      end
   endtask

   task automatic test_sequential();
      do_reset();
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         total++;
         if (obs() !== ((i % 2 == 0) ? ST_FETCH : ST_EXEC) ||
             ctr !== AW'(i / 2 + i % 2)) begin
            bad++;
            $display("FAIL seq_cycle%0d: got strobes=%b ctr=%h want %b ctr=%h", i, obs(), ctr,
                     (i % 2 == 0) ? ST_FETCH : ST_EXEC, AW'(i / 2 + i % 2));
         end
      end
      total++;
      if (ctr !== 12'h003) begin
         bad++;
         $display("FAIL seq_final_pc: got %h want 003", ctr);
      end
   endtask

   task automatic test_jump();
      do_reset();
      begin_run();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         @(negedge clk);
      end
      @(negedge clk);
      total++;
      if (obs() !== ST_EXEC || ctr !== 12'h005) begin
         bad++;
         $display("FAIL jump_exec: got strobes=%b ctr=%h want %b ctr=005", obs(), ctr, ST_EXEC);
      end
      jump_req  = 1'b1;
      jump_addr = 12'hA30;
      @(negedge clk);
      clear_reqs();
      total++;
      if (obs() !== ST_LOAD || pc_value !== 12'hA30) begin
         bad++;
         $display("FAIL jump_load: got strobes=%b val=%h want %b val=a30", obs(), pc_value, ST_LOAD);
      end
      @(negedge clk);
      total++;
      if (obs() !== ST_FETCH || ctr !== 12'hA30) begin
         bad++;
         $display("FAIL jump_fetch: got strobes=%b ctr=%h want %b ctr=a30", obs(), ctr, ST_FETCH);
      end
      @(negedge clk);
      total++;
      if (ctr !== 12'hA31) begin
         bad++;
         $display("FAIL jump_next: got ctr=%h want a31", ctr);
      end
   endtask

   task automatic test_call_ret();
      do_reset();
      begin_run();
      @(negedge clk);
      jump_req  = 1'b1;
      jump_addr = 12'h010;
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      @(negedge clk);
      total++;
      if (ctr !== 12'h011 || sp !== 3'd0) begin
         bad++;
         $display("FAIL call_pre: got ctr=%h sp=%0d want 011 sp=0", ctr, sp);
      end
      call_req  = 1'b1;
      jump_addr = 12'h200;
      @(negedge clk);
      clear_reqs();
      total++;
      if (obs() !== ST_LOAD || pc_value !== 12'h200 || sp !== 3'd1) begin
         bad++;
         $display("FAIL call_load: got strobes=%b val=%h sp=%0d want %b 200 1", obs(), pc_value, sp, ST_LOAD);
      end
      @(negedge clk);
      @(negedge clk);
      ret_req = 1'b1;
      @(negedge clk);
      clear_reqs();
      total++;
      if (obs() !== ST_LOAD || pc_value !== 12'h011 || sp !== 3'd0) begin
         bad++;
         $display("FAIL ret_load: got strobes=%b val=%h sp=%0d want %b 011 0", obs(), pc_value, sp, ST_LOAD);
      end
      @(negedge clk);
      total++;
      if (ctr !== 12'h011) begin
         bad++;
         $display("FAIL ret_fetch: got ctr=%h want 011", ctr);
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      begin_run();
      @(negedge clk);
      call_req  = 1'b1;
      jump_addr = 12'h123;
      @(negedge clk);
      clear_reqs();
      total++;
      if (pc_load !== 1'b1) begin
         bad++;
         $display("FAIL midload_pre: got pc_load=%b want 1", pc_load);
      end
      reset = 1'b1;
      #1;
      total++;
      if (obs() !== ST_IDLE || sp !== 3'd0 || pc_value !== '0) begin
         bad++;
         $display("FAIL midload_reset: got strobes=%b sp=%0d val=%h want 00000 0 000", obs(), sp, pc_value);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      begin_run();
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         call_req  = 1'b1;
         jump_addr = AW'(c * 256 + 64);
         @(negedge clk);
         clear_reqs();
         total++;
         if (sp !== 3'(c + 1) || pc_load !== 1'b1) begin
            bad++;
            $display("FAIL ovf_call%0d: got sp=%0d load=%b want %0d 1", c, sp, pc_load, c + 1);
         end
         @(negedge clk);
      end
      @(negedge clk);
      call_req  = 1'b1;
      jump_addr = 12'h777;
      @(negedge clk);
      clear_reqs();
      total++;
      if (stack_err !== 1'b1 || obs() !== ST_IDLE || sp !== 3'd4) begin
         bad++;
         $display("FAIL ovf_err: got err=%b strobes=%b sp=%0d want 1 00000 4", stack_err, obs(), sp);
      end
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs() !== ST_IDLE || stack_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_start_ignored: got strobes=%b err=%b want 00000 1", obs(), stack_err);
         end
      end
      start = 1'b0;
      reset = 1'b1;
      #1;
      total++;
      if (stack_err !== 1'b0 || sp !== 3'd0) begin
         bad++;
         $display("FAIL ovf_reset: got err=%b sp=%0d want 0 0", stack_err, sp);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_underflow_halt();
      do_reset();
      begin_run();
      @(negedge clk);
      ret_req = 1'b1;
      @(negedge clk);
      clear_reqs();
      total++;
      if (stack_err !== 1'b1 || obs() !== ST_IDLE) begin
         bad++;
         $display("FAIL udf_err: got err=%b strobes=%b want 1 00000", stack_err, obs());
      end
      do_reset();
      begin_run();
      @(negedge clk);
      call_req  = 1'b1;
      jump_addr = 12'h300;
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      @(negedge clk);
      halt_req  = 1'b1;
      jump_req  = 1'b1;
      jump_addr = 12'h777;
      @(negedge clk);
      clear_reqs();
      total++;
      if (obs() !== ST_HALT || pc_value !== 12'h300 || ctr !== 12'h301) begin
         bad++;
         $display("FAIL halt_enter: got strobes=%b val=%h ctr=%h want %b 300 301", obs(), pc_value, ctr, ST_HALT);
      end
      @(negedge clk);
      total++;
      if (obs() !== ST_HALT || sp !== 3'd1) begin
         bad++;
         $display("FAIL halt_hold: got strobes=%b sp=%0d want %b 1", obs(), sp, ST_HALT);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (obs() !== ST_FETCH || ctr !== 12'h301) begin
         bad++;
         $display("FAIL halt_resume: got strobes=%b ctr=%h want %b 301", obs(), ctr, ST_FETCH);
      end
      @(negedge clk);
      ret_req = 1'b1;
      @(negedge clk);
      clear_reqs();
      total++;
      if (pc_value !== 12'h001 || sp !== 3'd0 || pc_load !== 1'b1) begin
         bad++;
         $display("FAIL halt_ret: got val=%h sp=%0d load=%b want 001 0 1", pc_value, sp, pc_load);
      end
   endtask

   task automatic test_skip();
      do_reset();
      begin_run();
      @(negedge clk);
      jump_req  = 1'b1;
      jump_addr = 12'h008;
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      total++;
      if (ctr !== 12'h008) begin
         bad++;
         $display("FAIL skip_pre: got ctr=%h want 008", ctr);
      end
      @(negedge clk);
      skip_req = 1'b1;
      @(negedge clk);
      clear_reqs();
`ifdef SKIP_SEQ_EN
      total++;
      if (obs() !== ST_SKIP) begin
         bad++;
         $display("FAIL skip_state: got %b want %b", obs(), ST_SKIP);
      end
      @(negedge clk);
      total++;
      if (obs() !== ST_FETCH || ctr !== 12'h00A) begin
         bad++;
         $display("FAIL skip_fetch: got strobes=%b ctr=%h want %b 00a", obs(), ctr, ST_FETCH);
      end
`else
      total++;
      if (obs() !== ST_FETCH || ctr !== 12'h009) begin
         bad++;
         $display("FAIL noskip_fetch: got strobes=%b ctr=%h want %b 009", obs(), ctr, ST_FETCH);
      end
`endif
   endtask

   // Instruction-level model: each instruction is fetched at exp_pc, executes
   // with pc_in = exp_pc+1, and decides the next fetch address from the
   // highest-priority request. exp_q holds the expected return addresses.
   task automatic test_random();
      logic [AW-1:0] exp_q[$];
      logic [AW-1:0] exp_pc;
      logic [AW-1:0] nxt;
      logic [AW-1:0] tgt;
      logic          h, r, c, j, s;
      int            kind;
      do_reset();
      begin_run();
      exp_pc = '0;
      for (int n = 0; n < 300; n++) begin
         total++;
         if (obs() !== ST_FETCH || ctr !== exp_pc) begin
            bad++;
            $display("FAIL rnd_fetch%0d: got strobes=%b ctr=%h want %b %h", n, obs(), ctr, ST_FETCH, exp_pc);
         end
         nxt = exp_pc + AW'(1);
         @(negedge clk);
         total++;
         if (obs() !== ST_EXEC || ctr !== nxt || sp !== 3'(exp_q.size())) begin
            bad++;
            $display("FAIL rnd_exec%0d: got strobes=%b ctr=%h sp=%0d want %b %h %0d",
                     n, obs(), ctr, sp, ST_EXEC, nxt, exp_q.size());
         end
         h = ($urandom_range(0, 15) == 0);
         r = ($urandom_range(0, 3) == 0) && (exp_q.size() > 0);
         c = ($urandom_range(0, 3) == 0) && (exp_q.size() < DEPTH);
         j = ($urandom_range(0, 2) == 0);
         s = ($urandom_range(0, 2) == 0);
         jump_addr = AW'($urandom_range(0, 4095));
         {halt_req, ret_req, call_req, jump_req, skip_req} = {h, r, c, j, s};
         tgt  = '0;
         kind = 0;
         if (h) begin
            kind = 1;
         end else if (r) begin
            kind = 2;
            tgt  = exp_q.pop_back();
         end else if (c) begin
            kind = 2;
            exp_q.push_back(nxt);
            tgt  = jump_addr;
         end else if (j) begin
            kind = 2;
            tgt  = jump_addr;
         end else if (s) begin
`ifdef SKIP_SEQ_EN
            kind = 3;
`endif
         end
         @(negedge clk);
         clear_reqs();
         case (kind)
            1: begin
               total++;
               if (obs() !== ST_HALT) begin
                  bad++;
                  $display("FAIL rnd_halt%0d: got %b want %b", n, obs(), ST_HALT);
               end
               for (int w = 0; w < int'($urandom_range(0, 2)); w++) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start  = 1'b0;
               exp_pc = nxt;
            end
            2: begin
               total++;
               if (obs() !== ST_LOAD || pc_value !== tgt) begin
                  bad++;
                  $display("FAIL rnd_load%0d: got strobes=%b val=%h want %b %h", n, obs(), pc_value, ST_LOAD, tgt);
               end
               @(negedge clk);
               exp_pc = tgt;
            end
            3: begin
               total++;
               if (obs() !== ST_SKIP) begin
                  bad++;
                  $display("FAIL rnd_skip%0d: got %b want %b", n, obs(), ST_SKIP);
               end
               @(negedge clk);
               exp_pc = nxt + AW'(1);
            end
            default: exp_pc = nxt;
         endcase
      end
      total++;
      if (stack_err !== 1'b0) begin
         bad++;
         $display("FAIL rnd_no_err: got %b want 0", stack_err);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      clear_reqs();
      test_reset();
      test_sequential();
      test_jump();
      test_call_ret();
      test_reset_mid_load();
      test_overflow();
      test_underflow_halt();
      test_skip();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
